fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: memory data width.
REQ-003 SHALL have parameter VECTOR_ADDR, default 16'hFFFC: low byte of reset vector; high byte at VECTOR_ADDR+1.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port mem_enable  output  1  memory access strobe.
REQ-007 SHALL have port mem_address  output  ADDR_WIDTH  memory address.
REQ-008 SHALL have port mem_wr_enable  output  1  write strobe, constant 0 (read-only initiator).
REQ-009 SHALL have port mem_rd_data  input  DATA_WIDTH  read data, valid one cycle after the address is presented with mem_enable=1.
REQ-010 SHALL have port redirect_valid  input  1  one-cycle request to restart fetch at redirect_addr.
REQ-011 SHALL have port redirect_addr  input  ADDR_WIDTH  new fetch address.
REQ-012 SHALL have port out_valid  output  1  fetched byte available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts byte.
REQ-014 SHALL have port out_data  output  DATA_WIDTH  fetched byte.
REQ-015 SHALL have port out_addr  output  ADDR_WIDTH  address of out_data.
REQ-016 SHALL have port vector_done  output  1  high once PC is loaded from the reset vector.

Function
REQ-017 SHALL implement states VEC_LO, VEC_HI, VEC_LOAD, FETCH.
REQ-018 VEC_LO SHALL drive mem_enable=1, mem_address=VECTOR_ADDR for one cycle, then go to VEC_HI.
REQ-019 VEC_HI SHALL capture mem_rd_data as vector low byte, drive VECTOR_ADDR+1, then go to VEC_LOAD.
REQ-020 VEC_LOAD SHALL set pc={mem_rd_data, low byte}, deassert mem_enable, set vector_done=1, then go to FETCH.
REQ-021 FETCH SHALL issue a read at pc (mem_enable=1) only when buffer occupancy plus in-flight reads is below buffer depth, then increment pc.
REQ-022 Read data SHALL be written into the output buffer with its address on the cycle after issue.
REQ-023 Output buffer SHALL be FIFO-ordered; a byte is consumed when out_valid && out_ready on a rising edge.
REQ-024 Simultaneous write and read of the buffer SHALL leave occupancy unchanged.
REQ-025 pc SHALL wrap from 16'hFFFF to 16'h0000 with no other effect.
REQ-026 redirect_valid SHALL, at the next edge, flush the buffer, discard any in-flight read's data, and set pc=redirect_addr; the first read at redirect_addr SHALL issue in the following cycle.
REQ-027 redirect_valid in any VEC_* state SHALL abandon the vector fetch, set vector_done=1, and enter FETCH at redirect_addr.
REQ-028 out_valid, out_data, out_addr SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 mem_wr_enable SHALL be 0 in every state.

Reset
REQ-030 While reset=1: state=VEC_LO, mem_enable=0, mem_address=0, pc=0, buffer empty, out_valid=0, out_data=0, out_addr=0, vector_done=0.
REQ-031 The first VEC_LO access SHALL occur in the first cycle after reset deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all buffered and in-flight data immediately.

Configuration
REQ-033 Macro FETCH_PREFETCH_EN defined: buffer depth 2, allowing one read issued every cycle at full throughput with out_ready=1.
REQ-034 Macro FETCH_PREFETCH_EN undefined: buffer depth 1, at most one read in flight; throughput one byte per 2 cycles.

Verification
REQ-035 Memory FFFC=00, FFFD=80; release reset -> reads FFFC then FFFD on consecutive cycles, vector_done=1 at VEC_LOAD, next read address 8000.
REQ-036 8000=A9, 8001=05, 8002=8D, out_ready=1 -> out_data A9,05,8D with out_addr 8000,8001,8002 in order; with FETCH_PREFETCH_EN, one byte per cycle.
REQ-037 Hold out_ready=0 for 5 cycles -> no reads beyond buffer depth, out_data stable at A9, no bytes lost after out_ready=1.
REQ-038 redirect_valid with redirect_addr=9000 while 2 bytes buffered -> buffer flushed, next out_addr=9000, no stale 80xx byte emitted.
REQ-039 Vector FFFF: pc=FFFF -> bytes at FFFF then 0000 emitted, out_addr wraps.
REQ-040 Assert reset during FETCH with out_valid=1 -> out_valid=0 at once; after release, vector re-fetched from FFFC.

Source files
------------

// File: rtl/fetch_unit.sv
// Byte-wide instruction fetch unit: loads PC from a two-byte reset vector, then streams bytes into a small FIFO.
// Optional macro FETCH_PREFETCH_EN deepens the buffer to 2 for one-byte-per-cycle throughput.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] VECTOR_ADDR = 16'hFFFC
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_wr_enable,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  vector_done
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef enum logic [1:0] {VEC_LO, VEC_HI, VEC_LOAD, FETCH} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic [DATA_WIDTH-1:0] vec_lo_reg;
    logic                  vec_done_reg;
    logic                  inflight_reg;
    logic [ADDR_WIDTH-1:0] inflight_addr_reg;
    logic [1:0]            count_reg, count_next;
    logic [DATA_WIDTH-1:0] buf_data_reg  [DEPTH];
    logic [ADDR_WIDTH-1:0] buf_addr_reg  [DEPTH];
    logic [DATA_WIDTH-1:0] buf_data_next [DEPTH];
    logic [ADDR_WIDTH-1:0] buf_addr_next [DEPTH];
    logic                  issue, push, pop;
    logic [1:0]            wr_idx;
    logic [2:0]            occupancy;

    assign pop  = (count_reg != 2'd0) && out_ready;
    // Data returning for a read is dropped if a redirect lands on the same edge.
    assign push = inflight_reg && !redirect_valid;
    // Counting the byte leaving this cycle lets a read issue back-to-back with the pop.
    assign occupancy = {1'b0, count_reg} - {2'b00, pop} + {2'b00, inflight_reg};
    assign wr_idx    = count_reg - {1'b0, pop};

    assign count_next = redirect_valid ? 2'd0 : (count_reg + {1'b0, push} - {1'b0, pop});

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        mem_enable  = 1'b0;
        mem_address = pc_reg;
        issue       = 1'b0;
        case (state_reg)
            VEC_LO: begin
                mem_enable  = 1'b1;
                mem_address = VECTOR_ADDR;
                state_next  = VEC_HI;
            end
            VEC_HI: begin
                mem_enable  = 1'b1;
                mem_address = VECTOR_ADDR + ADDR_WIDTH'(1);
                state_next  = VEC_LOAD;
            end
            VEC_LOAD: begin
                pc_next    = ADDR_WIDTH'({mem_rd_data, vec_lo_reg});
                state_next = FETCH;
            end
            FETCH: begin
                if (occupancy < 3'(DEPTH)) begin
                    issue       = 1'b1;
                    mem_enable  = 1'b1;
                    mem_address = pc_reg;
                    pc_next     = pc_reg + ADDR_WIDTH'(1);
                end
            end
            default: state_next = VEC_LO;
        endcase
        if (redirect_valid) begin
            state_next = FETCH;
            pc_next    = redirect_addr;
            mem_enable = 1'b0;
            issue      = 1'b0;
        end
        if (reset) begin
            mem_enable  = 1'b0;
            mem_address = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= VEC_LO;
            pc_reg            <= '0;
            vec_lo_reg        <= '0;
            vec_done_reg      <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_addr_reg <= '0;
            count_reg         <= 2'd0;
        end else begin
            state_reg         <= state_next;
            pc_reg            <= pc_next;
            if (state_reg == VEC_HI) begin
                vec_lo_reg <= mem_rd_data;
            end
            if (state_reg == VEC_LOAD || redirect_valid) begin
                vec_done_reg <= 1'b1;
            end
            inflight_reg      <= issue;
            inflight_addr_reg <= pc_reg;
            count_reg         <= count_next;
        end
    end

    // Head of the FIFO is always entry 0; a pop shifts the remaining entries down.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] shift_data;
            logic [ADDR_WIDTH-1:0] shift_addr;
            if (gi + 1 < DEPTH) begin : g_shift
                assign shift_data = buf_data_reg[gi+1];
                assign shift_addr = buf_addr_reg[gi+1];
            end else begin : g_last
                assign shift_data = buf_data_reg[gi];
                assign shift_addr = buf_addr_reg[gi];
            end
            assign buf_data_next[gi] = (push && wr_idx == 2'(gi)) ? mem_rd_data :
                                       (pop ? shift_data : buf_data_reg[gi]);
            assign buf_addr_next[gi] = (push && wr_idx == 2'(gi)) ? inflight_addr_reg :
                                       (pop ? shift_addr : buf_addr_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_reg[i] <= '0;
                buf_addr_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_reg[i] <= buf_data_next[i];
                buf_addr_reg[i] <= buf_addr_next[i];
            end
        end
    end

    assign out_valid     = (count_reg != 2'd0);
    assign out_data      = buf_data_reg[0];
    assign out_addr      = buf_addr_reg[0];
    assign mem_wr_enable = 1'b0;
    assign vector_done   = vec_done_reg || (state_reg == VEC_LOAD);

endmodule
